// File: rtl/acct_arbiter.sv
// acct_arbiter: round-robin arbiter granting one requester at a time access
// to an access-control table. Each transaction takes three states
// (IDLE -> ACCESS -> RESP). Index range and per-entry write locks are
// checked before the table is touched.
module acct_arbiter #(
  parameter int NB_REQ         = 4,
  parameter int NB_ENTRY       = 10,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_REQ-1:0]         req_i,
  input  logic [NB_REQ-1:0]         we_i,
  input  logic [NB_REQ*8-1:0]       idx_i,
  input  logic [NB_REQ*32-1:0]      wdata_i,
  input  logic [NB_ENTRY-1:0]       lock_i,
  output logic [NB_REQ-1:0]         gnt_o,
  output logic [NB_REQ-1:0]         done_o,
  output logic                      err_o,
  output logic [31:0]               rdata_o,
  output logic                      tbl_en_o,
  output logic                      tbl_we_o,
  output logic [AXI_ADDR_WIDTH-1:0] tbl_addr_o,
  output logic [AXI_DATA_WIDTH-1:0] tbl_wdata_o,
  input  logic [AXI_DATA_WIDTH-1:0] tbl_rdata_i
);

  localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam logic [7:0] NB_ENTRY_B = 8'(NB_ENTRY);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NB_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [PTR_W-1:0] win_reg, win_next;
  logic             we_reg, we_next;
  logic [7:0]       idx_reg, idx_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic             bad_reg, bad_next;

  logic [PTR_W-1:0] arb_win;
  logic             arb_found;
  int               cand;
  logic             lock_sel;
  logic             bad_now;
  logic             in_access;
  logic             unused_rdata_hi;

  logic [7:0]  idx_arr   [NB_REQ];
  logic [31:0] wdata_arr [NB_REQ];

  assign in_access = (state_reg == ACCESS);

  // Unpack per-requester fields and decode the one-hot grant/done strobes.
  generate
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_req
      assign idx_arr[gi]   = idx_i[8*gi +: 8];
      assign wdata_arr[gi] = wdata_i[32*gi +: 32];
      assign gnt_o[gi]     = in_access && (win_reg == PTR_W'(gi));
      assign done_o[gi]    = (state_reg == RESP) && (win_reg == PTR_W'(gi));
    end
  endgenerate

  // Round-robin search: first set request at or above ptr, wrapping to 0.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = ptr_reg;
    cand      = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      cand = int'(ptr_reg) + i;
      if (cand >= NB_REQ) cand = cand - NB_REQ;
      if (!arb_found && req_i[PTR_W'(cand)]) begin
        arb_found = 1'b1;
        arb_win   = PTR_W'(cand);
      end
    end
  end

  // Legality of the latched transaction; lock is looked up only for valid indexes.
  always_comb begin
    lock_sel = 1'b0;
    for (int e = 0; e < NB_ENTRY; e++) begin
      if (idx_reg == 8'(e)) lock_sel = lock_i[e];
    end
    bad_now = (idx_reg >= NB_ENTRY_B) || (we_reg && lock_sel);
  end

  // Next-state and latched-field updates for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    win_next   = win_reg;
    we_next    = we_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    bad_next   = bad_reg;
    case (state_reg)
      IDLE: begin
        if (arb_found) begin
          state_next = ACCESS;
          win_next   = arb_win;
          we_next    = we_i[arb_win];
          idx_next   = idx_arr[arb_win];
          wdata_next = wdata_arr[arb_win];
        end
      end
      ACCESS: begin
        state_next = RESP;
        bad_next   = bad_now;
        rdata_next = (!bad_now && !we_reg) ? tbl_rdata_i[31:0] : 32'd0;
      end
      RESP: begin
        state_next = IDLE;
        ptr_next   = (win_reg == LAST_REQ) ? '0 : win_reg + PTR_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // State and latched fields; reset aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      we_reg    <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      bad_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
      we_reg    <= we_next;
      idx_reg   <= idx_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      bad_reg   <= bad_next;
    end
  end

  assign tbl_en_o    = in_access && !bad_now;
  assign tbl_we_o    = tbl_en_o && we_reg;
  assign tbl_addr_o  = in_access ? (AXI_ADDR_WIDTH'(idx_reg) << 3) : '0;
  assign tbl_wdata_o = in_access ? AXI_DATA_WIDTH'(wdata_reg) : '0;
  assign err_o       = (state_reg == RESP) && bad_reg;
  assign rdata_o     = rdata_reg;

  // Only the low word of a table entry is returned to requesters.
  assign unused_rdata_hi = ^tbl_rdata_i[AXI_DATA_WIDTH-1:32];

endmodule

// File: tb/tb_acct_arbiter.sv
// Self-checking bench for acct_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level reference model.
module tb_acct_arbiter;

  localparam int NB_REQ   = 4;
  localparam int NB_ENTRY = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req, we;
  logic [7:0]    t_idx   [NB_REQ];
  logic [31:0]   t_wdata [NB_REQ];
  logic [31:0]   idx_v;
  logic [127:0]  wdata_v;
  logic [9:0]    lock;
  logic [63:0]   tbl_rdata;
  logic [3:0]    gnt, done;
  logic          err, ten, twe;
  logic [31:0]   rdata;
  logic [63:0]   taddr, twdata;
  logic [170:0]  obs;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  logic [31:0] m_rdata = 32'd0;

  always #5 clk = ~clk;

  always_comb begin
    idx_v   = '0;
    wdata_v = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      idx_v[8*k +: 8]    = t_idx[k];
      wdata_v[32*k +: 32] = t_wdata[k];
    end
  end

  assign obs = {gnt, done, err, rdata, ten, twe, taddr, twdata};

  acct_arbiter #(.NB_REQ(4), .NB_ENTRY(10), .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .idx_i(idx_v),
    .wdata_i(wdata_v), .lock_i(lock), .gnt_o(gnt), .done_o(done), .err_o(err),
    .rdata_o(rdata), .tbl_en_o(ten), .tbl_we_o(twe), .tbl_addr_o(taddr),
    .tbl_wdata_o(twdata), .tbl_rdata_i(tbl_rdata)
  );

  function automatic logic [170:0] mk(input logic [3:0] g, input logic [3:0] d, input logic e,
                                      input logic [31:0] rd, input logic en, input logic w,
                                      input logic [63:0] a, input logic [63:0] wd);
    return {g, d, e, rd, en, w, a, wd};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; we = '0; lock = '0; tbl_rdata = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      t_idx[k] = '0; t_wdata[k] = '0;
    end
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_ptr = 0;
    m_rdata = 32'd0;
  endtask

  // Transaction-level model: pick the winner, judge legality, and predict the
  // ACCESS and RESP cycle outputs from the current stimulus.
  task automatic model_txn(output logic found, output int w,
                           output logic [170:0] e_acc, output logic [170:0] e_resp);
    int c;
    int ix;
    logic wr, bad;
    found = 1'b0; w = 0;
    for (int i = 0; i < NB_REQ; i++) begin
      c = (m_ptr + i) % NB_REQ;
      if (!found && req[c]) begin found = 1'b1; w = c; end
    end
    if (!found) begin
      e_acc  = mk(0, 0, 0, m_rdata, 0, 0, 0, 0);
      e_resp = e_acc;
      return;
    end
    ix  = int'(t_idx[w]);
    wr  = we[w];
    bad = (ix >= NB_ENTRY) ? 1'b1 : (wr && lock[ix]);
    e_acc = mk(4'(1 << w), 0, 0, m_rdata, !bad, !bad && wr, 64'(ix * 8), {32'd0, t_wdata[w]});
    m_rdata = (!bad && !wr) ? tbl_rdata[31:0] : 32'd0;
    e_resp = mk(0, 4'(1 << w), bad, m_rdata, 0, 0, 0, 0);
    m_ptr = (w + 1) % NB_REQ;
  endtask

  task automatic test_reset();
    clear_inputs();
    req = 4'b1111;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected 0", i, obs);
      end
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single_write();
    logic [170:0] e;
    reset_dut();
    req = 4'b0001; we = 4'b0001; t_idx[0] = 8'd2; t_wdata[0] = 32'hA5A5_0001;
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL sw_idle: got %h expected 0", obs); end
    step();
    e = mk(4'b0001, 0, 0, 0, 1, 1, 64'h10, 64'h0000_0000_A5A5_0001);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL sw_access: got %h expected %h", obs, e); end
    req = '0;
    step();
    e = mk(0, 4'b0001, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL sw_resp: got %h expected %h", obs, e); end
    step();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL sw_after: got %h expected 0", obs); end
  endtask

  task automatic test_fairness();
    int gcyc[$];
    logic [3:0] gval[$];
    reset_dut();
    req = 4'b1111;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      step();
      if (gnt !== 4'b0000) begin gcyc.push_back(cyc); gval.push_back(gnt); end
    end
    checks++;
    if (gcyc.size() < 5) begin
      errors++;
      $display("FAIL fair_count: got %0d grants expected 5 or more", gcyc.size());
    end
    for (int k = 0; k < 5 && k < gcyc.size(); k++) begin
      checks++;
      if (gval[k] !== 4'(1 << (k % 4))) begin
        errors++;
        $display("FAIL fair_order[%0d]: got %b expected %b", k, gval[k], 4'(1 << (k % 4)));
      end
      checks++;
      if (gcyc[k] != 1 + 3 * k) begin
        errors++;
        $display("FAIL fair_spacing[%0d]: got cycle %0d expected %0d", k, gcyc[k], 1 + 3 * k);
      end
    end
  endtask

  task automatic test_locked_write();
    logic [170:0] e;
    reset_dut();
    lock = 10'b00_0000_1000;
    req = 4'b0100; we = 4'b0100; t_idx[2] = 8'd3; t_wdata[2] = 32'hCAFE_F00D;
    step();
    e = mk(4'b0100, 0, 0, 0, 0, 0, 64'h18, 64'h0000_0000_CAFE_F00D);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lock_access: got %h expected %h", obs, e); end
    req = '0;
    step();
    e = mk(0, 4'b0100, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lock_resp: got %h expected %h", obs, e); end
    step();
  endtask

  task automatic test_good_then_oor_read();
    logic [170:0] e;
    reset_dut();
    req = 4'b1000; t_idx[3] = 8'd9; tbl_rdata = 64'h1234_5678_DEAD_BEEF;
    step();
    e = mk(4'b1000, 0, 0, 0, 1, 0, 64'h48, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rd_access: got %h expected %h", obs, e); end
    req = '0;
    step();
    e = mk(0, 4'b1000, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL rd_resp: got %h expected %h", obs, e); end
    tbl_rdata = 64'h0;
    for (int i = 0; i < 2; i++) begin
      step();
      e = mk(0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rd_hold[%0d]: got %h expected %h", i, obs, e); end
    end
    req = 4'b0001; t_idx[0] = 8'd12; tbl_rdata = 64'hFFFF_FFFF_1111_2222;
    step();
    e = mk(4'b0001, 0, 0, 32'hDEAD_BEEF, 0, 0, 64'h60, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL oor_access: got %h expected %h", obs, e); end
    req = '0;
    step();
    e = mk(0, 4'b0001, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL oor_resp: got %h expected %h", obs, e); end
    step();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    req = 4'b0010; t_idx[1] = 8'd1;
    step();
    checks++;
    if (gnt !== 4'b0010) begin errors++; $display("FAIL rm_grant: got %b expected 0010", gnt); end
    rst = 1'b1;
    step();
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL rm_cleared: got %h expected 0", obs); end
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL rm_no_done[%0d]: got %h expected 0", i, obs); end
    end
    req = 4'b1111;
    step();
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_first_grant: got %b expected 0001", gnt); end
    req = '0;
    step();
    step();
  endtask

  task automatic test_random();
    logic found;
    int w;
    logic [170:0] e_acc, e_resp, e_idle;
    reset_dut();
    for (int it = 0; it < 60; it++) begin
      req = 4'($urandom_range(0, 15));
      we  = 4'($urandom_range(0, 15));
      lock = 10'($urandom);
      tbl_rdata = {$urandom, $urandom};
      for (int k = 0; k < NB_REQ; k++) begin
        t_idx[k] = 8'($urandom_range(0, 13));
        t_wdata[k] = $urandom;
      end
      e_idle = mk(0, 0, 0, m_rdata, 0, 0, 0, 0);
      checks++;
      if (obs !== e_idle) begin errors++; $display("FAIL rnd_idle[%0d]: got %h expected %h", it, obs, e_idle); end
      model_txn(found, w, e_acc, e_resp);
      if (!found) begin
        step();
        continue;
      end
      @(posedge clk);
      #1;
      // Requester fields move after the grant; the latched copy must be used.
      req = 4'($urandom_range(0, 15));
      we  = ~we;
      for (int k = 0; k < NB_REQ; k++) begin
        t_idx[k] = 8'($urandom);
        t_wdata[k] = $urandom;
      end
      #1;
      checks++;
      if (obs !== e_acc) begin errors++; $display("FAIL rnd_access[%0d]: got %h expected %h", it, obs, e_acc); end
      step();
      checks++;
      if (obs !== e_resp) begin errors++; $display("FAIL rnd_resp[%0d]: got %h expected %h", it, obs, e_resp); end
      step();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_write();
    test_fairness();
    test_locked_write();
    test_good_then_oor_read();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acct_arbiter.md
ACCT_ARBITER -- requirements
Module: acct_arbiter

Interface
REQ-001 Parameters SHALL be:
- NB_REQ, 4, number of requesters.
- NB_ENTRY, 10, number of access-control table entries; valid indexes are 0..NB_ENTRY-1.
- AXI_ADDR_WIDTH, 64, table address width.
- AXI_DATA_WIDTH, 64, table data width.

REQ-002 The block SHALL have one clock; reset is synchronous and active-high.

REQ-003 Ports SHALL be:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  NB_REQ  per-requester request.
- we_i  in  NB_REQ  per-requester write (1) / read (0).
- idx_i  in  NB_REQ*8  per-requester entry index; slice k = [8k+:8].
- wdata_i  in  NB_REQ*32  per-requester write data; slice k = [32k+:32].
- lock_i  in  NB_ENTRY  per-entry write lock.
- gnt_o  out  NB_REQ  one-hot grant.
- done_o  out  NB_REQ  one-hot completion pulse.
- err_o  out  1  error flag, valid with done_o.
- rdata_o  out  32  read result.
- tbl_en_o  out  1  table access enable.
- tbl_we_o  out  1  table write enable.
- tbl_addr_o  out  AXI_ADDR_WIDTH  table address.
- tbl_wdata_o  out  AXI_DATA_WIDTH  table write data.
- tbl_rdata_i  in  AXI_DATA_WIDTH  table read data, combinational from the table.

Function
REQ-004 The FSM SHALL have three states:
- IDLE -> ACCESS when any req_i bit is 1; otherwise it stays in IDLE.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.

REQ-005 Arbitration in IDLE SHALL be round-robin: the winner is the first set req_i bit searching upward from pointer ptr, wrapping from NB_REQ-1 to 0.

REQ-006 On the IDLE->ACCESS transition the block SHALL latch the winner's index, we_i bit, idx_i slice and wdata_i slice; later changes on those inputs SHALL have no effect on the transaction.

REQ-007 The transaction SHALL be flagged bad when either:
- the latched idx >= NB_ENTRY, or
- it is a write and lock_i[idx] = 1 (lock sampled in ACCESS).

REQ-008 In ACCESS:
- gnt_o[winner] SHALL be 1.
- tbl_en_o SHALL be 1 and tbl_we_o SHALL equal the latched we, only if the transaction is not bad; otherwise both SHALL be 0.
- tbl_addr_o SHALL be the zero-extended idx shifted left by 3.
- tbl_wdata_o SHALL be the zero-extended latched wdata.

REQ-009 Outside ACCESS, gnt_o, tbl_en_o, tbl_we_o, tbl_addr_o and tbl_wdata_o SHALL all be 0.

REQ-010 In ACCESS, for a good read, rdata_o SHALL be loaded with tbl_rdata_i[31:0] at the clock edge; for any write or bad transaction it SHALL be loaded with 0.

REQ-011 In RESP:
- done_o[winner] SHALL pulse for exactly one cycle.
- err_o SHALL be 1 if the transaction is bad, else 0.
- ptr SHALL be updated to (winner+1) mod NB_REQ.
- Outside RESP, done_o and err_o SHALL be 0.

REQ-012 rdata_o SHALL hold its value until the next ACCESS cycle.

REQ-013 Latency SHALL be fixed:
- request sampled in IDLE at cycle N;
- grant and table access at cycle N+1;
- done at cycle N+2;
- next arbitration no earlier than cycle N+3, i.e. at most one transaction per 3 cycles.

REQ-014 Requester handshake rules:
- A requester SHALL hold req_i and its fields stable until its done_o pulse.
- req_i still high in the cycle after done_o SHALL be treated as a new request.
- A requester that deasserts req_i before being granted SHALL be dropped without error.

REQ-015 Only one table access SHALL ever be in flight, and gnt_o and done_o SHALL never have more than one bit set.

Reset
REQ-016 When rst_i = 1 at a clock edge:
- state SHALL go to IDLE and ptr to 0;
- all latched fields and rdata_o SHALL be cleared to 0;
- all outputs SHALL be 0 in the following cycle.

REQ-017 Reset asserted during ACCESS or RESP SHALL abort the transaction: no done_o pulse is produced for it, and any table write already issued in ACCESS stands.

REQ-018 The first arbitration after reset deassertion SHALL start from requester 0.

Verification
REQ-019 Single write:
- Stimulus: req_i=0001, we_i[0]=1, idx=2, wdata=0xA5A50001, lock_i=0.
- Response: cycle+1 gnt_o=0001, tbl_en_o=1, tbl_we_o=1, tbl_addr_o=0x10, tbl_wdata_o=0x00000000A5A50001; cycle+2 done_o=0001, err_o=0.

REQ-020 Fairness:
- Stimulus: req_i=1111 held continuously.
- Response: grants in order 0,1,2,3,0, spaced exactly 3 cycles apart.

REQ-021 Locked write:
- Stimulus: lock_i[3]=1, requester 2 writes idx 3.
- Response: tbl_en_o stays 0 throughout; done_o=0100 with err_o=1.

REQ-022 Out-of-range read:
- Stimulus: read of idx 12 (NB_ENTRY=10).
- Response: tbl_en_o=0, err_o=1, rdata_o=0.

REQ-023 Good read:
- Stimulus: read of idx 9 with tbl_rdata_i=0x12345678DEADBEEF.
- Response: tbl_addr_o=0x48 in ACCESS; rdata_o=0xDEADBEEF from the RESP cycle onward, err_o=0.

REQ-024 Reset mid-operation:
- Stimulus: rst_i=1 during ACCESS of requester 1.
- Response: no done_o pulse; all outputs 0 the next cycle; a subsequent req_i=1111 is granted to requester 0 first.
